driver_74hc595: RTL and testbench

DRIVER_74HC595 -- requirements
Module: driver_74hc595

---
 rtl/driver_74hc595.sv | 102 ++++++++++
 tb/tb_driver_74hc595.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/driver_74hc595.sv
// Serial driver for four daisy-chained 74HC595 shift-register chains sharing SRCLK/RCLK.
// Optional active-low output enable OEn is built when DRIVER_74HC595_OE_EN is defined.
module driver_74hc595 #(
  parameter int unsigned CHAIN_LEN = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CHAIN_LEN-1:0] data_0,
  input  logic [CHAIN_LEN-1:0] data_1,
  input  logic [CHAIN_LEN-1:0] data_2,
  input  logic [CHAIN_LEN-1:0] data_3,
  output logic                 SER_0,
  output logic                 SER_1,
  output logic                 SER_2,
  output logic                 SER_3,
  output logic                 SRCLK,
  output logic                 RCLK,
  output logic                 frame_done
`ifdef DRIVER_74HC595_OE_EN
  ,
  output logic                 OEn
`endif
);

  localparam int unsigned FRAME = 2 * CHAIN_LEN + 4;
  localparam int unsigned CW    = $clog2(FRAME);

  localparam logic [CW-1:0] LAST      = CW'(FRAME - 1);
  localparam logic [CW-1:0] LATCH     = CW'(FRAME - 2);
  localparam logic [CW-1:0] FIRST_BIT = CW'(2);
  localparam logic [CW-1:0] LAST_BIT  = CW'(2 * CHAIN_LEN + 1);

  logic                      r_run;
  logic [CW-1:0]             r_cnt;
  logic [3:0][CHAIN_LEN-1:0] r_shadow;
  logic [3:0]                r_ser;

  logic                      w_load;
  logic                      w_in_bits;
  logic                      w_shift;
  logic                      w_srclk;
  logic                      w_rclk;
  logic [CW-1:0]             w_cnt_nxt;
  logic [3:0][CHAIN_LEN-1:0] w_data;

  assign w_data = {data_3, data_2, data_1, data_0};

  // Outputs are registered from the decode of the cycle about to start (w_cnt_nxt).
  always_comb begin
    w_cnt_nxt = '0;
    if (r_run && (r_cnt != LAST)) begin
      w_cnt_nxt = r_cnt + CW'(1);
    end
    w_load    = r_run && (r_cnt == '0);
    w_in_bits = (w_cnt_nxt >= FIRST_BIT) && (w_cnt_nxt <= LAST_BIT);
    w_shift   = w_in_bits && !w_cnt_nxt[0];
    w_srclk   = w_in_bits && w_cnt_nxt[0];
    w_rclk    = (w_cnt_nxt == LATCH);
  end

  // r_run distinguishes the reset-held state from frame cycle 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_run      <= 1'b0;
      r_cnt      <= '0;
      r_shadow   <= '0;
      r_ser      <= '0;
      SRCLK      <= 1'b0;
      RCLK       <= 1'b0;
      frame_done <= 1'b0;
`ifdef DRIVER_74HC595_OE_EN
      OEn        <= 1'b1;
`endif
    end else begin
      r_run      <= 1'b1;
      r_cnt      <= w_cnt_nxt;
      SRCLK      <= w_srclk;
      RCLK       <= w_rclk;
      frame_done <= w_rclk;
      if (w_load) begin
        r_shadow <= w_data;
      end else if (w_shift) begin
        for (int i = 0; i < 4; i++) begin
          r_ser[i]    <= r_shadow[i][CHAIN_LEN-1];
          r_shadow[i] <= {r_shadow[i][CHAIN_LEN-2:0], 1'b0};
        end
      end
`ifdef DRIVER_74HC595_OE_EN
      // Enable only once a full frame has been latched into the chains.
      if (w_cnt_nxt == LAST) begin
        OEn <= 1'b0;
      end
`endif
    end
  end

  assign SER_0 = r_ser[0];
  assign SER_1 = r_ser[1];
  assign SER_2 = r_ser[2];
  assign SER_3 = r_ser[3];

endmodule

// File: tb/tb_driver_74hc595.sv
// Bench for driver_74hc595: 74HC595 chain model plus frame-timing rules, table and random stimulus.
// Honours DRIVER_74HC595_OE_EN when defined.
module tb_driver_74hc595;

  localparam int unsigned N  = 16;
  localparam int          FR = 2 * N + 4;

  logic         clk    = 1'b0;
  logic         reset  = 1'b1;
  logic [N-1:0] data_0 = '0;
  logic [N-1:0] data_1 = '0;
  logic [N-1:0] data_2 = '0;
  logic [N-1:0] data_3 = '0;
  logic         SER_0, SER_1, SER_2, SER_3;
  logic         SRCLK, RCLK, frame_done;
`ifdef DRIVER_74HC595_OE_EN
  logic         OEn;
`endif

  driver_74hc595 #(.CHAIN_LEN(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .data_0     (data_0),
    .data_1     (data_1),
    .data_2     (data_2),
    .data_3     (data_3),
    .SER_0      (SER_0),
    .SER_1      (SER_1),
    .SER_2      (SER_2),
    .SER_3      (SER_3),
    .SRCLK      (SRCLK),
    .RCLK       (RCLK),
    .frame_done (frame_done)
`ifdef DRIVER_74HC595_OE_EN
    ,
    .OEn        (OEn)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [N-1:0] d [4];
    logic [N-1:0] e [4];
  } vec_t;

  int           n_tests = 0;
  int           n_fail  = 0;
  int           fc      = -1;
  logic         oen_st  = 1'b1;
  logic [3:0]   prev_ser   = '0;
  logic         prev_srclk = 1'b0;
  logic         prev_rclk  = 1'b0;
  logic [N-1:0] sr  [4];
  logic [N-1:0] lat [4];
  int           nsr     = 0;
  int           n_rclk  = 0;
  int           n_latch = 0;
  logic [4*N-1:0] q_exp[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (frame cycle %0d, t=%0t)", name, act, exp, fc, $time);
    end
  endtask

  // One clock: note data seen by the edge ending cycle 0, then check outputs at the falling edge.
  task automatic tick();
    logic       rst_at_edge;
    logic [3:0] ser;
    logic [4*N-1:0] e;
    rst_at_edge = reset;
    if (!reset && fc == 0) q_exp.push_back({data_3, data_2, data_1, data_0});
    @(negedge clk);
    ser = {SER_3, SER_2, SER_1, SER_0};
    if (rst_at_edge) begin
      fc = -1;
      oen_st = 1'b1;
      q_exp.delete();
      nsr = 0;
      chk("rst_ser", 64'(ser), 64'(0));
      chk("rst_srclk", 64'(SRCLK), 64'(0));
      chk("rst_rclk", 64'(RCLK), 64'(0));
      chk("rst_frame_done", 64'(frame_done), 64'(0));
`ifdef DRIVER_74HC595_OE_EN
      chk("rst_oen", 64'(OEn), 64'(1));
`endif
    end else begin
      fc = (fc < 0) ? 0 : (fc + 1) % FR;
      if (fc == FR - 1) oen_st = 1'b0;
      chk("clk_exclusive", 64'(SRCLK & RCLK), 64'(0));
      chk("done_eq_rclk", 64'(frame_done), 64'(RCLK));
      chk("rclk_timing", 64'(RCLK), 64'(fc == FR - 2));
      chk("srclk_timing", 64'(SRCLK), 64'(fc >= 3 && fc <= 2 * N + 1 && (fc % 2) == 1));
      if (!(fc >= 2 && fc <= 2 * N && (fc % 2) == 0))
        chk("ser_hold", 64'(ser), 64'(prev_ser));
`ifdef DRIVER_74HC595_OE_EN
      chk("oen", 64'(OEn), 64'(oen_st));
`endif
      if (SRCLK && !prev_srclk) begin
        for (int i = 0; i < 4; i++) sr[i] = {sr[i][N-2:0], ser[i]};
        nsr++;
      end
      if (RCLK && !prev_rclk) begin
        n_rclk++;
        chk("srclk_pulses", 64'(nsr), 64'(N));
        nsr = 0;
        for (int i = 0; i < 4; i++) lat[i] = sr[i];
        chk("latch_pending", 64'(q_exp.size()), 64'(1));
        if (q_exp.size() > 0) begin
          e = q_exp.pop_front();
          chk("latch_value", 64'({lat[3], lat[2], lat[1], lat[0]}), 64'(e));
          n_latch++;
        end
      end
    end
    prev_ser   = ser;
    prev_srclk = SRCLK;
    prev_rclk  = RCLK;
  endtask

  task automatic run_to(input int target);
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (fc != target && k < 200);
    chk("reach_cycle", 64'(fc), 64'(target));
  endtask

  initial begin
    vec_t tbl[4];
    int   rb;
    int   rst_left;

    tbl[0].d = '{16'hA5C3, 16'h0000, 16'h0000, 16'h0000};
    tbl[0].e = '{16'hA5C3, 16'h0000, 16'h0000, 16'h0000};
    tbl[1].d = '{16'h0001, 16'h8000, 16'hFFFF, 16'h0000};
    tbl[1].e = '{16'h0001, 16'h8000, 16'hFFFF, 16'h0000};
    tbl[2].d = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
    tbl[2].e = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
    tbl[3].d = '{16'hFFFF, 16'h0001, 16'h8000, 16'hAAAA};
    tbl[3].e = '{16'hFFFF, 16'h0001, 16'h8000, 16'hAAAA};
    for (int i = 0; i < 4; i++) begin
      sr[i]  = '0;
      lat[i] = '0;
    end

    // Reset held for five clocks.
    reset = 1'b1;
    for (int i = 0; i < 5; i++) tick();

    // Table vectors: one frame each, release reset with the first one applied.
    for (int v = 0; v < 4; v++) begin
      data_0 = tbl[v].d[0];
      data_1 = tbl[v].d[1];
      data_2 = tbl[v].d[2];
      data_3 = tbl[v].d[3];
      reset  = 1'b0;
      run_to(FR - 2);
      for (int i = 0; i < 4; i++) chk($sformatf("table%0d_chain%0d", v, i), 64'(lat[i]), 64'(tbl[v].e[i]));
      run_to(FR - 1);
    end

    // Data changing mid-frame is deferred to the next frame.
    data_0 = 16'h0000;
    run_to(10);
    data_0 = 16'hFFFF;
    run_to(FR - 2);
    chk("midframe_current", 64'(lat[0]), 64'(16'h0000));
    run_to(FR - 2);
    chk("midframe_next", 64'(lat[0]), 64'(16'hFFFF));

    // Reset at cycle 20 for two clocks aborts the frame.
    data_0 = 16'h3C5A;
    run_to(20);
    rb = n_rclk;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("restart_cycle0", 64'(fc), 64'(0));
    chk("abort_no_rclk", 64'(n_rclk), 64'(rb));
    run_to(FR - 2);
    chk("after_abort_latch", 64'(lat[0]), 64'(16'h3C5A));
    run_to(FR - 1);
`ifdef DRIVER_74HC595_OE_EN
    chk("oen_low_after_first_frame", 64'(OEn), 64'(0));
`endif

    // Random data changes at any cycle plus occasional short resets.
    rst_left = 0;
    for (int c = 0; c < 1200; c++) begin
      tick();
      if (rst_left > 0) begin
        rst_left--;
        if (rst_left == 0) reset = 1'b0;
      end else if ($urandom_range(0, 299) == 0) begin
        reset    = 1'b1;
        rst_left = $urandom_range(1, 3);
      end
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 3))
          0: data_0 = 16'($urandom);
          1: data_1 = 16'($urandom);
          2: data_2 = 16'($urandom);
          default: data_3 = 16'($urandom);
        endcase
      end
    end
    reset = 1'b0;
    run_to(FR - 1);
    chk("latches_seen", 64'(n_latch >= 20), 64'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
